life_stepper: RTL and testbench

- Computes the next Game-of-Life generation of the toroidal board, one WORD_SIZE-bit word at a time.
- Sits directly upstream of the renderer. The board memory is double-banked: the renderer reads the display bank, and this block reads that same bank through a second port and writes the other bank.
- Once a generation is complete, the banks swap only while the renderer reports its blank period (done_out). This keeps a frame from ever showing a mixed generation.

---
 rtl/life_stepper_pkg.sv | 32 +++
 rtl/life_stepper_if.sv | 15 +
 rtl/life_stepper_word_next.sv | 28 ++
 rtl/life_stepper.sv | 144 ++++++++++++++
 tb/tb_life_stepper.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/life_stepper_pkg.sv
// Shared board geometry, word/address types and FSM encoding for the Life stepper.
package life_stepper_pkg;
    localparam int BOARD_SIZE        = 256;
    localparam int WORD_SIZE         = 32;
    localparam int LOG_BOARD_SIZE    = $clog2(BOARD_SIZE);
    localparam int LOG_WORD_SIZE     = $clog2(WORD_SIZE);
    localparam int WORDS_PER_ROW     = BOARD_SIZE / WORD_SIZE;
    localparam int LOG_WORDS_PER_ROW = LOG_BOARD_SIZE - LOG_WORD_SIZE;
    localparam int LOG_MAX_ADDR      = LOG_BOARD_SIZE + LOG_WORDS_PER_ROW;
    localparam int PRELOAD_CYCLES    = 6;
    localparam int SWEEP_CYCLES      = 4;

    typedef logic [LOG_BOARD_SIZE-1:0]    pos_t;
    typedef logic [LOG_WORDS_PER_ROW-1:0] wx_t;
    typedef logic [LOG_MAX_ADDR-1:0]      addr_t;
    typedef logic [WORD_SIZE-1:0]         word_t;

    typedef enum logic { BANK_0, BANK_1 } bank_sel_t;

    typedef enum logic [1:0] { IDLE, PRELOAD, SWEEP, SWAP_WAIT } state_t;

    // Window slot that the word returning next cycle belongs to.
    typedef struct packed {
        logic       valid;
        logic [1:0] row;
        logic [1:0] col;
    } win_tgt_t;

    function automatic addr_t word_addr(input pos_t y, input wx_t wx);
        return {y, wx};
    endfunction
endpackage

// File: rtl/life_stepper_if.sv
// Board memory port pair: read from the display bank, write to the back bank.
interface life_stepper_if;
    import life_stepper_pkg::*;

    addr_t rd_addr_out;
    word_t rd_data_in;
    addr_t wr_addr_out;
    word_t wr_data_out;
    logic  wr_en_out;

    modport master (output rd_addr_out, wr_addr_out, wr_data_out, wr_en_out,
                    input  rd_data_in);
    modport slave  (input  rd_addr_out, wr_addr_out, wr_data_out, wr_en_out,
                    output rd_data_in);
endinterface

// File: rtl/life_stepper_word_next.sv
// Combinational next-generation word from a 3x3 window of words (up/mid/down, left/centre/right).
module life_word_next
    import life_stepper_pkg::*;
(
    input  word_t up_l_i, input word_t up_c_i, input word_t up_r_i,
    input  word_t md_l_i, input word_t md_c_i, input word_t md_r_i,
    input  word_t dn_l_i, input word_t dn_c_i, input word_t dn_r_i,
    output word_t next_o
);
    // Each row extended by one neighbour cell on each side; centre bit i sits at [i+1].
    logic [WORD_SIZE+1:0] up_x, md_x, dn_x;
    logic [3:0]           n;

    assign up_x = {up_l_i[0], up_c_i, up_r_i[WORD_SIZE-1]};
    assign md_x = {md_l_i[0], md_c_i, md_r_i[WORD_SIZE-1]};
    assign dn_x = {dn_l_i[0], dn_c_i, dn_r_i[WORD_SIZE-1]};

    always_comb begin
        next_o = '0;
        n      = '0;
        for (int i = 0; i < WORD_SIZE; i++) begin
            n = 4'(up_x[i]) + 4'(up_x[i+1]) + 4'(up_x[i+2])
              + 4'(md_x[i])                 + 4'(md_x[i+2])
              + 4'(dn_x[i]) + 4'(dn_x[i+1]) + 4'(dn_x[i+2]);
            next_o[i] = (n == 4'd3) | (md_x[i+1] & (n == 4'd2));
        end
    end
endmodule

// File: rtl/life_stepper.sv
// Sweeps the display bank word by word, writes the next generation to the back bank,
// and swaps banks only during the renderer's blank period.
module life_stepper
    import life_stepper_pkg::*;
(
    input  logic           clk_130mhz,
    input  logic           rst_n_in,
    input  logic           step_in,
    input  logic           frame_done_in,
    life_stepper_if.master mem,
    output logic           display_bank_out,
    output logic           busy_out,
    output logic [15:0]    gen_count_out
);
    state_t      state_q, state_d;
    pos_t        y_q, y_d;
    wx_t         wx_q, wx_d;
    logic [2:0]  ph_q, ph_d;
    win_tgt_t    tgt_q, tgt_d;
    bank_sel_t   bank_q;
    logic [15:0] gen_q;
    word_t       win_q [3][3];

    logic        rd_act, wr_act, swap;
    logic [1:0]  rd_row;
    wx_t         rd_wx;
    pos_t        rd_y;
    word_t       next_word;

    always_comb begin
        state_d = state_q;
        y_d     = y_q;
        wx_d    = wx_q;
        ph_d    = ph_q;
        tgt_d   = '0;
        rd_act  = 1'b0;
        rd_row  = '0;
        rd_wx   = '0;
        wr_act  = 1'b0;
        swap    = 1'b0;
        case (state_q)
            IDLE: if (step_in) begin
                state_d = PRELOAD;
                y_d     = '0;
                wx_d    = '0;
                ph_d    = '0;
            end
            PRELOAD: begin
                // Pairs of reads per row: wrapped left word (WPR-1), then word 0 as centre.
                rd_act = 1'b1;
                rd_row = ph_q[2:1];
                rd_wx  = ph_q[0] ? wx_t'(0) : wx_t'(WORDS_PER_ROW-1);
                tgt_d  = '{valid: 1'b1, row: ph_q[2:1], col: (ph_q[0] ? 2'd1 : 2'd0)};
                if (ph_q == 3'(PRELOAD_CYCLES-1)) begin
                    state_d = SWEEP;
                    ph_d    = '0;
                end else begin
                    ph_d = ph_q + 3'd1;
                end
            end
            SWEEP: begin
                if (ph_q == 3'(SWEEP_CYCLES-1)) begin
                    wr_act = 1'b1;
                    ph_d   = '0;
                    wx_d   = wx_q + wx_t'(1);
                    if (wx_q == wx_t'(WORDS_PER_ROW-1)) begin
                        if (y_q == pos_t'(BOARD_SIZE-1)) begin
                            state_d = SWAP_WAIT;
                        end else begin
                            y_d     = y_q + pos_t'(1);
                            state_d = PRELOAD;
                        end
                    end
                end else begin
                    rd_act = 1'b1;
                    rd_row = ph_q[1:0];
                    rd_wx  = wx_q + wx_t'(1);
                    tgt_d  = '{valid: 1'b1, row: ph_q[1:0], col: 2'd2};
                    ph_d   = ph_q + 3'd1;
                end
            end
            SWAP_WAIT: if (frame_done_in) begin
                swap    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_130mhz or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= IDLE;
            y_q     <= '0;
            wx_q    <= '0;
            ph_q    <= '0;
            tgt_q   <= '0;
            bank_q  <= BANK_0;
            gen_q   <= '0;
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
            wx_q    <= wx_d;
            ph_q    <= ph_d;
            tgt_q   <= tgt_d;
            if (swap) begin
                bank_q <= (bank_q == BANK_0) ? BANK_1 : BANK_0;
                gen_q  <= gen_q + 16'd1;
            end
        end
    end

    // On the write cycle the last right-column word is still on rd_data_in, so it is
    // shifted straight into the centre instead of being captured first.
    always_ff @(posedge clk_130mhz or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    win_q[r][c] <= '0;
        end else if (wr_act) begin
            for (int r = 0; r < 3; r++) begin
                win_q[r][0] <= win_q[r][1];
                win_q[r][1] <= (r == 2) ? mem.rd_data_in : win_q[r][2];
            end
        end else if (tgt_q.valid) begin
            win_q[tgt_q.row][tgt_q.col] <= mem.rd_data_in;
        end
    end

    life_word_next u_next (
        .up_l_i (win_q[0][0]), .up_c_i (win_q[0][1]), .up_r_i (win_q[0][2]),
        .md_l_i (win_q[1][0]), .md_c_i (win_q[1][1]), .md_r_i (win_q[1][2]),
        .dn_l_i (win_q[2][0]), .dn_c_i (win_q[2][1]), .dn_r_i (mem.rd_data_in),
        .next_o (next_word)
    );

    assign rd_y             = y_q + pos_t'(rd_row) - pos_t'(1);
    assign mem.rd_addr_out  = rd_act ? word_addr(rd_y, rd_wx) : '0;
    assign mem.wr_en_out    = wr_act;
    assign mem.wr_addr_out  = wr_act ? word_addr(y_q, wx_q) : '0;
    assign mem.wr_data_out  = wr_act ? next_word : '0;
    assign display_bank_out = (bank_q == BANK_1);
    assign busy_out         = (state_q != IDLE);
    assign gen_count_out    = gen_q;
endmodule

// File: tb/tb_life_stepper.sv
// Scoreboarded bench: a cell-array reference model predicts every back-bank write.
module tb_life_stepper;
    import life_stepper_pkg::*;

    localparam int GEN_CYCLES = BOARD_SIZE * (PRELOAD_CYCLES + SWEEP_CYCLES * WORDS_PER_ROW);
    localparam int NWORDS     = BOARD_SIZE * WORDS_PER_ROW;

    typedef struct { addr_t a; word_t d; } wr_t;

    logic        clk = 1'b0, rst_n = 1'b0, step = 1'b0, frame_done = 1'b0;
    logic        bank, busy;
    logic [15:0] gen;

    life_stepper_if mem_if();

    life_stepper dut (
        .clk_130mhz       (clk),
        .rst_n_in         (rst_n),
        .step_in          (step),
        .frame_done_in    (frame_done),
        .mem              (mem_if),
        .display_bank_out (bank),
        .busy_out         (busy),
        .gen_count_out    (gen)
    );

    always #5 clk = ~clk;

    word_t                 mem [2][NWORDS];
    word_t                 img [NWORDS];
    logic                  ld_req = 1'b0;
    logic                  ld_bank = 1'b0;
    logic [BOARD_SIZE-1:0] board [BOARD_SIZE];
    logic [BOARD_SIZE-1:0] nb    [BOARD_SIZE];
    wr_t                   exp_q [$];
    wr_t                   e;
    int                    total = 0, bad = 0;
    int                    wr_cnt = 0, cyc = 0, last_wr_cyc = 0;
    int                    hi, w0, live;
    logic                  bank_m = 1'b0;
    logic [15:0]           gen_m = '0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        mem_if.rd_data_in <= mem[bank][mem_if.rd_addr_out];
        if (ld_req) begin
            for (int a = 0; a < NWORDS; a++) mem[ld_bank][a] <= img[a];
        end else if (mem_if.wr_en_out) begin
            mem[!bank][mem_if.wr_addr_out] <= mem_if.wr_data_out;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: every write strobe must match the next predicted word.
    always @(negedge clk) begin
        if (rst_n && mem_if.wr_en_out) begin
            if (exp_q.size() == 0) begin
                chk("wr_unexpected", {53'd0, mem_if.wr_addr_out}, 64'hFFFF);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", mem_if.wr_addr_out, e.a);
                chk("wr_data", mem_if.wr_data_out, e.d);
                if (e.a != 0)
                    chk("wr_gap", cyc - last_wr_cyc,
                        (e.a[LOG_WORDS_PER_ROW-1:0] == 0) ? 10 : 4);
            end
            last_wr_cyc = cyc;
            wr_cnt++;
        end
    end

    function automatic word_t pack_word(input logic [BOARD_SIZE-1:0] row, input int wx);
        word_t w;
        for (int j = 0; j < WORD_SIZE; j++) w[WORD_SIZE-1-j] = row[wx*WORD_SIZE + j];
        return w;
    endfunction

    function automatic logic mcell(input logic b, input int x, input int y);
        int xx, yy;
        xx = (x + BOARD_SIZE) % BOARD_SIZE;
        yy = (y + BOARD_SIZE) % BOARD_SIZE;
        return mem[b][yy*WORDS_PER_ROW + xx/WORD_SIZE][WORD_SIZE-1 - xx%WORD_SIZE];
    endfunction

    function automatic int mcount(input logic b, input int x0, input int y0, input int x1, input int y1);
        int c = 0;
        for (int y = y0; y <= y1; y++)
            for (int x = x0; x <= x1; x++)
                c += int'(mcell(b, x, y));
        return c;
    endfunction

    task automatic calc_next();
        int n;
        for (int y = 0; y < BOARD_SIZE; y++)
            for (int x = 0; x < BOARD_SIZE; x++) begin
                n = 0;
                for (int dy = -1; dy <= 1; dy++)
                    for (int dx = -1; dx <= 1; dx++)
                        if (dx != 0 || dy != 0)
                            n += int'(board[(y+dy+BOARD_SIZE)%BOARD_SIZE][(x+dx+BOARD_SIZE)%BOARD_SIZE]);
                nb[y][x] = (n == 3) || (board[y][x] && n == 2);
            end
    endtask

    task automatic load_board(input logic b);
        for (int y = 0; y < BOARD_SIZE; y++)
            for (int wx = 0; wx < WORDS_PER_ROW; wx++)
                img[y*WORDS_PER_ROW + wx] = pack_word(board[y], wx);
        ld_bank = b;
        ld_req  = 1'b1;
        @(posedge clk);
        #1 ld_req = 1'b0;
    endtask

    task automatic random_board();
        for (int y = 0; y < BOARD_SIZE; y++)
            for (int k = 0; k < WORDS_PER_ROW; k++)
                board[y][k*WORD_SIZE +: WORD_SIZE] = $urandom;
    endtask

    task automatic do_step(input bit accept);
        @(negedge clk);
        step = 1'b1;
        if (accept) begin
            calc_next();
            for (int y = 0; y < BOARD_SIZE; y++)
                for (int wx = 0; wx < WORDS_PER_ROW; wx++)
                    exp_q.push_back('{a: addr_t'(y*WORDS_PER_ROW + wx), d: pack_word(nb[y], wx)});
        end
        @(posedge clk);
        #1 step = 1'b0;
    endtask

    task automatic wait_idle(output int cnt);
        cnt = 0;
        for (int i = 0; i < GEN_CYCLES + 2000; i++) begin
            @(negedge clk);
            if (!busy) break;
            cnt++;
        end
    endtask

    task automatic wait_wr(input int target);
        for (int i = 0; i < GEN_CYCLES + 2000 && wr_cnt < target; i++) @(negedge clk);
        chk("wr_reach", wr_cnt >= target, 1);
    endtask

    task automatic swapped_model();
        for (int y = 0; y < BOARD_SIZE; y++) board[y] = nb[y];
        bank_m = !bank_m;
        gen_m  = gen_m + 16'd1;
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int y = 0; y < BOARD_SIZE; y++) board[y] = '0;
        board[9][10]  = 1'b1; board[10][10] = 1'b1; board[11][10] = 1'b1;
        board[31][31] = 1'b1; board[31][32] = 1'b1; board[32][31] = 1'b1; board[32][32] = 1'b1;
        board[255][0] = 1'b1; board[0][1] = 1'b1; board[1][255] = 1'b1;
        board[1][0]   = 1'b1; board[1][1] = 1'b1;

        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_bank", bank, 0);
        chk("rst_gen", gen, 0);
        chk("rst_wr_en", mem_if.wr_en_out, 0);
        chk("rst_rd_addr", mem_if.rd_addr_out, 0);
        chk("rst_wr_addr", mem_if.wr_addr_out, 0);
        chk("rst_wr_data", mem_if.wr_data_out, 0);
        load_board(1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        frame_done = 1'b1;

        for (int g = 1; g <= 4; g++) begin
            w0 = wr_cnt;
            do_step(1'b1);
            wait_idle(hi);
            chk("busy_cycles", hi, GEN_CYCLES + 1);
            chk("writes_per_gen", wr_cnt - w0, NWORDS);
            chk("queue_empty", exp_q.size(), 0);
            swapped_model();
            chk("bank", bank, bank_m);
            chk("gen_count", gen, gen_m);
            if (g == 1) begin
                chk("blinker_l", mcell(bank_m, 9, 10), 1);
                chk("blinker_c", mcell(bank_m, 10, 10), 1);
                chk("blinker_r", mcell(bank_m, 11, 10), 1);
                chk("blinker_cnt", mcount(bank_m, 5, 5, 15, 15), 3);
            end
            if (g == 3) begin
                chk("block_a", mcell(bank_m, 31, 31), 1);
                chk("block_d", mcell(bank_m, 32, 32), 1);
                chk("block_cnt", mcount(bank_m, 28, 28, 35, 35), 4);
            end
            if (g == 4) begin
                chk("glider_cnt", mcount(bank_m, -4, -4, 6, 6), 5);
                live = int'(mcell(bank_m, 1, 0)) + int'(mcell(bank_m, 2, 1)) + int'(mcell(bank_m, 0, 2))
                     + int'(mcell(bank_m, 1, 2)) + int'(mcell(bank_m, 2, 2));
                chk("glider_shape", live, 5);
            end
        end

        random_board();
        load_board(bank_m);
        frame_done = 1'b0;
        w0 = wr_cnt;
        do_step(1'b1);
        wait_wr(w0 + 1000);
        do_step(1'b0);
        wait_wr(w0 + NWORDS);
        repeat (20) @(negedge clk);
        chk("hold_bank", bank, bank_m);
        chk("hold_busy", busy, 1);
        chk("hold_gen", gen, gen_m);
        frame_done = 1'b1;
        @(negedge clk);
        swapped_model();
        chk("swap_bank", bank, bank_m);
        chk("swap_busy", busy, 0);
        chk("swap_gen", gen, gen_m);
        repeat (12) @(negedge clk);
        chk("no_queued_step", busy, 0);
        chk("queue_empty", exp_q.size(), 0);

        w0 = wr_cnt;
        do_step(1'b1);
        wait_wr(w0 + 300);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_wr_en", mem_if.wr_en_out, 0);
        chk("arst_busy", busy, 0);
        chk("arst_bank", bank, 0);
        chk("arst_gen", gen, 0);
        exp_q.delete();
        random_board();
        load_board(1'b0);
        @(negedge clk);
        rst_n  = 1'b1;
        bank_m = 1'b0;
        gen_m  = '0;
        w0 = wr_cnt;
        do_step(1'b1);
        wait_idle(hi);
        chk("post_rst_cycles", hi, GEN_CYCLES + 1);
        chk("post_rst_writes", wr_cnt - w0, NWORDS);
        chk("queue_empty", exp_q.size(), 0);
        swapped_model();
        chk("post_rst_bank", bank, bank_m);
        chk("post_rst_gen", gen, gen_m);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
